// File: rtl/fase2_pkg.sv
// Shared constants and enums for the multicycle RV32I subset core.
// Opcodes, funct fields, FSM states and ALU operations.
package fase2_pkg;

    localparam logic [6:0] OP_R   = 7'h33;
    localparam logic [6:0] OP_I   = 7'h13;
    localparam logic [6:0] OP_LW  = 7'h03;
    localparam logic [6:0] OP_SW  = 7'h23;
    localparam logic [6:0] OP_BR  = 7'h63;
    localparam logic [6:0] OP_SYS = 7'h73;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_SUB  = 7'h20;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5
    } alu_op_t;

    typedef enum logic [1:0] {
        IMM_I = 2'd0,
        IMM_S = 2'd1,
        IMM_B = 2'd2
    } imm_sel_t;

endpackage

// File: rtl/fase2_multiciclo_control_unit.sv
// FSM and instruction decode for the multicycle core.
// Drives datapath enables; dmem_we and halted are registered.
module control_unit
    import fase2_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       eq,
    output logic [2:0] state_o,
    output logic       ir_we,
    output logic       ab_we,
    output logic       alu_we,
    output logic       mdr_we,
    output logic       rf_we,
    output logic       wb_mdr,
    output logic       pc_we,
    output logic       pc_br,
    output logic       alu_src_imm,
    output logic [2:0] alu_op,
    output logic [1:0] imm_sel,
    output logic       dmem_we,
    output logic       halted
);

    state_t state;
    logic   is_r, is_i, is_lw, is_sw, is_br, legal, taken;

    always_comb begin
        is_r = (opcode == OP_R) &&
               (((funct7 == F7_BASE) &&
                 ((funct3 == F3_ADD) || (funct3 == F3_SLT) ||
                  (funct3 == F3_XOR) || (funct3 == F3_OR) ||
                  (funct3 == F3_AND))) ||
                ((funct7 == F7_SUB) && (funct3 == F3_ADD)));
        is_i = (opcode == OP_I) &&
               ((funct3 == F3_ADD) || (funct3 == F3_OR) ||
                (funct3 == F3_AND));
        is_lw = (opcode == OP_LW);
        is_sw = (opcode == OP_SW);
        is_br = (opcode == OP_BR) &&
                ((funct3 == F3_BEQ) || (funct3 == F3_BNE));
        legal = is_r | is_i | is_lw | is_sw | is_br;
        taken = (funct3 == F3_BNE) ? !eq : eq;
    end

    always_comb begin
        alu_op = ALU_ADD;
        if (is_r) begin
            case (funct3)
                F3_ADD:  alu_op = funct7[5] ? ALU_SUB : ALU_ADD;
                F3_SLT:  alu_op = ALU_SLT;
                F3_XOR:  alu_op = ALU_XOR;
                F3_OR:   alu_op = ALU_OR;
                F3_AND:  alu_op = ALU_AND;
                default: alu_op = ALU_ADD;
            endcase
        end else if (is_i) begin
            case (funct3)
                F3_OR:   alu_op = ALU_OR;
                F3_AND:  alu_op = ALU_AND;
                default: alu_op = ALU_ADD;
            endcase
        end else if (is_br) begin
            alu_op = ALU_SUB;
        end
    end

    always_comb begin
        imm_sel     = is_sw ? IMM_S : (is_br ? IMM_B : IMM_I);
        alu_src_imm = !(is_r || is_br);
        wb_mdr      = is_lw;
        ir_we       = (state == S_FETCH);
        ab_we       = (state == S_DECODE);
        alu_we      = (state == S_EXECUTE);
        mdr_we      = (state == S_MEM) && is_lw;
        rf_we       = (state == S_WB);
        pc_br       = (state == S_EXECUTE) && is_br && taken;
        pc_we       = ((state == S_EXECUTE) && is_br) ||
                      ((state == S_MEM) && is_sw) ||
                      (state == S_WB);
    end

    assign state_o = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_FETCH;
            dmem_we <= 1'b0;
            halted  <= 1'b0;
        end else begin
            case (state)
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    if (!legal) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        state <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    if (is_br) begin
                        state <= S_FETCH;
                    end else if (is_lw || is_sw) begin
                        state   <= S_MEM;
                        dmem_we <= is_sw;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    dmem_we <= 1'b0;
                    state   <= is_lw ? S_WB : S_FETCH;
                end
                S_WB:    state <= S_FETCH;
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: rtl/fase2_multiciclo.sv
// Multicycle RV32I subset core: datapath, register file and ALU.
// Sequencing lives in control_unit.
module fase2_multiciclo
    import fase2_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int IMEM_AW = 6,
    parameter int DMEM_AW = 6
) (
    input  logic               clk,
    input  logic               reset,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_data,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [XLEN-1:0]    dmem_wdata,
    output logic               dmem_we,
    input  logic [XLEN-1:0]    dmem_rdata,
    output logic [XLEN-1:0]    pc_o,
    output logic [2:0]         state_o,
    output logic               halted
);

    logic [XLEN-1:0] pc, a, b, imm, aluout, mdr;
    logic [XLEN-1:0] imm_n, opb, alu_y;
    logic [31:0]     ir;
    logic [XLEN-1:0] rf [32];

    logic       ir_we, ab_we, alu_we, mdr_we, rf_we;
    logic       wb_mdr, pc_we, pc_br, alu_src_imm;
    logic [2:0] alu_op;
    logic [1:0] imm_sel;
    logic [4:0] rs1, rs2, rd;

    assign rs1 = ir[19:15];
    assign rs2 = ir[24:20];
    assign rd  = ir[11:7];

    control_unit u_ctrl (
        .clk         (clk),
        .reset       (reset),
        .opcode      (ir[6:0]),
        .funct3      (ir[14:12]),
        .funct7      (ir[31:25]),
        .eq          (a == b),
        .state_o     (state_o),
        .ir_we       (ir_we),
        .ab_we       (ab_we),
        .alu_we      (alu_we),
        .mdr_we      (mdr_we),
        .rf_we       (rf_we),
        .wb_mdr      (wb_mdr),
        .pc_we       (pc_we),
        .pc_br       (pc_br),
        .alu_src_imm (alu_src_imm),
        .alu_op      (alu_op),
        .imm_sel     (imm_sel),
        .dmem_we     (dmem_we),
        .halted      (halted)
    );

    always_comb begin
        case (imm_sel)
            IMM_S:   imm_n = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   imm_n = {{(XLEN-13){ir[31]}}, ir[31], ir[7],
                              ir[30:25], ir[11:8], 1'b0};
            default: imm_n = {{(XLEN-12){ir[31]}}, ir[31:20]};
        endcase
    end

    always_comb begin
        opb = alu_src_imm ? imm : b;
        case (alu_op)
            ALU_SUB: alu_y = a - opb;
            ALU_AND: alu_y = a & opb;
            ALU_OR:  alu_y = a | opb;
            ALU_XOR: alu_y = a ^ opb;
            ALU_SLT: alu_y = {{(XLEN-1){1'b0}},
                              ($signed(a) < $signed(opb))};
            default: alu_y = a + opb;
        endcase
    end

    // Word addressing: the low two address bits are dropped on both ports.
    assign imem_addr  = pc[IMEM_AW+1:2];
    assign dmem_addr  = aluout[DMEM_AW+1:2];
    assign dmem_wdata = b;
    assign pc_o       = pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc     <= '0;
            ir     <= '0;
            a      <= '0;
            b      <= '0;
            imm    <= '0;
            aluout <= '0;
            mdr    <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            if (ir_we) ir <= imem_data;
            if (ab_we) begin
                a   <= rf[rs1];
                b   <= rf[rs2];
                imm <= imm_n;
            end
            if (alu_we) aluout <= alu_y;
            if (mdr_we) mdr <= dmem_rdata;
            if (rf_we && (rd != 5'd0)) rf[rd] <= wb_mdr ? mdr : aluout;
            if (pc_we) pc <= pc_br ? pc + imm : pc + XLEN'(4);
        end
    end

endmodule

// File: tb/tb_fase2_multiciclo.sv
// Self-checking bench for fase2_multiciclo against an ISA-level model.
// Directed programs plus randomized instruction streams.
module tb_fase2_multiciclo;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  imem_addr, dmem_addr;
    logic [31:0] imem_data, dmem_wdata, dmem_rdata, pc_o;
    logic        dmem_we, halted;
    logic [2:0]  state_o;

    logic [31:0] imem [64];
    logic [31:0] dmem [64];
    logic [31:0] mmem [64];
    logic [31:0] mregs [32];
    logic [31:0] mpc;

    int checks = 0;
    int passed = 0;

    fase2_multiciclo dut (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_we    (dmem_we),
        .dmem_rdata (dmem_rdata),
        .pc_o       (pc_o),
        .state_o    (state_o),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    assign imem_data  = imem[imem_addr];
    assign dmem_rdata = dmem[dmem_addr];

    always @(posedge clk) if (dmem_we) dmem[dmem_addr] = dmem_wdata;

    function automatic logic [31:0] enc_i(int op, int f3, int rd,
                                          int rs1, int imm);
        logic [11:0] v;
        v = imm[11:0];
        return {v, 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
    endfunction

    function automatic logic [31:0] enc_r(int f7, int f3, int rd,
                                          int rs1, int rs2);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(int rs1, int rs2, int imm);
        logic [11:0] v;
        v = imm[11:0];
        return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(int f3, int rs1, int rs2,
                                          int off);
        logic [12:0] o;
        o = off[12:0];
        return {o[12], o[10:5], 5'(rs2), 5'(rs1), 3'(f3),
                o[4:1], o[11], 7'h63};
    endfunction

    // ISA-level reference: executes one instruction on mregs/mmem/mpc.
    task automatic model_step(output int cyc, output bit st,
                              output logic [5:0] sa,
                              output logic [31:0] sd, output bit hlt);
        logic [31:0] ins, x, y, res, ea, immi, imms, immb;
        int rd, rs1, rs2, f3, f7;
        bit wr, br, tk;
        ins  = imem[mpc[7:2]];
        rd   = int'((ins >> 7) & 31);
        rs1  = int'((ins >> 15) & 31);
        rs2  = int'((ins >> 20) & 31);
        f3   = int'((ins >> 12) & 7);
        f7   = int'(ins >> 25);
        immi = 32'($signed(ins) >>> 20);
        imms = (32'($signed(ins) >>> 25) << 5) | ((ins >> 7) & 31);
        immb = (32'($signed(ins) >>> 31) << 12)
             | (((ins >> 7) & 1) << 11)
             | (((ins >> 25) & 63) << 5)
             | (((ins >> 8) & 15) << 1);
        x = mregs[rs1];
        y = mregs[rs2];
        st = 0; sa = 0; sd = 0; hlt = 0;
        wr = 0; br = 0; tk = 0; res = 0; cyc = 4; ea = 0;
        case (ins[6:0])
            7'h33: begin
                wr = 1;
                if (f7 == 0 && f3 == 0) res = x + y;
                else if (f7 == 32 && f3 == 0) res = x - y;
                else if (f7 == 0 && f3 == 2)
                    res = ($signed(x) < $signed(y)) ? 1 : 0;
                else if (f7 == 0 && f3 == 4) res = x ^ y;
                else if (f7 == 0 && f3 == 6) res = x | y;
                else if (f7 == 0 && f3 == 7) res = x & y;
                else hlt = 1;
            end
            7'h13: begin
                wr = 1;
                if (f3 == 0) res = x + immi;
                else if (f3 == 6) res = x | immi;
                else if (f3 == 7) res = x & immi;
                else hlt = 1;
            end
            7'h03: begin
                ea = x + immi;
                res = mmem[ea[7:2]];
                wr = 1;
                cyc = 5;
            end
            7'h23: begin
                ea = x + imms;
                st = 1;
                sa = ea[7:2];
                sd = y;
            end
            7'h63: begin
                br = 1;
                cyc = 3;
                if (f3 == 0) tk = (x == y);
                else if (f3 == 1) tk = (x != y);
                else hlt = 1;
            end
            default: hlt = 1;
        endcase
        if (hlt) begin
            cyc = 2;
            st = 0;
        end else begin
            if (wr && rd != 0) mregs[rd] = res;
            if (st) mmem[sa] = sd;
            mpc = (br && tk) ? mpc + immb : mpc + 4;
        end
    endtask

    // Runs the DUT from a FETCH until the next FETCH or HALT.
    task automatic dut_step(output int cyc, output int nwe,
                            output logic [5:0] wa,
                            output logic [31:0] wd);
        cyc = 0; nwe = 0; wa = 0; wd = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (dmem_we) begin
                nwe++;
                wa = dmem_addr;
                wd = dmem_wdata;
            end
        end while (state_o != 3'd0 && state_o != 3'd5 && cyc < 12);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        mpc = 0;
        for (int i = 0; i < 32; i++) mregs[i] = 0;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 64; i++) begin
            dmem[i] = $urandom;
            mmem[i] = dmem[i];
            imem[i] = 32'h00000073;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (pc_o !== 32'd0) $display("FAIL reset_pc got %h want 0", pc_o);
        else passed++;
        checks++;
        if (state_o !== 3'd0)
            $display("FAIL reset_state got %0d want 0", state_o);
        else passed++;
        checks++;
        if (halted !== 1'b0) $display("FAIL reset_halted got %b want 0", halted);
        else passed++;
        checks++;
        if (dmem_we !== 1'b0) $display("FAIL reset_we got %b want 0", dmem_we);
        else passed++;
    endtask

    task automatic test_directed();
        int ecyc[14], epc[14], est[14], esa[14];
        logic [31:0] esd[14];
        int cyc, nwe;
        logic [5:0] wa;
        logic [31:0] wd;
        fill_mem();
        imem[0]  = enc_i(19, 0, 1, 0, 5);
        imem[1]  = enc_i(19, 0, 2, 0, 7);
        imem[2]  = enc_r(0, 0, 3, 1, 2);
        imem[3]  = enc_s(0, 3, 8);
        imem[4]  = enc_i(3, 2, 4, 0, 8);
        imem[5]  = enc_s(0, 4, 12);
        imem[6]  = enc_i(19, 0, 0, 0, 9);
        imem[7]  = enc_r(0, 0, 5, 0, 0);
        imem[8]  = enc_s(0, 5, 16);
        imem[9]  = enc_r(32, 0, 6, 1, 2);
        imem[10] = enc_r(0, 2, 7, 6, 1);
        imem[11] = enc_s(0, 6, 20);
        imem[12] = enc_s(0, 7, 24);
        imem[13] = 32'h00000073;
        ecyc = '{4, 4, 4, 4, 5, 4, 4, 4, 4, 4, 4, 4, 4, 2};
        epc  = '{4, 8, 12, 16, 20, 24, 28, 32, 36, 40, 44, 48, 52, 52};
        est  = '{0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 1, 1, 0};
        esa  = '{0, 0, 0, 2, 0, 3, 0, 0, 4, 0, 0, 5, 6, 0};
        esd  = '{0, 0, 0, 12, 0, 12, 0, 0, 0, 0, 0,
                 32'hFFFFFFFE, 1, 0};
        do_reset();
        for (int k = 0; k < 14; k++) begin
            dut_step(cyc, nwe, wa, wd);
            checks++;
            if (cyc != ecyc[k])
                $display("FAIL dir_cycles[%0d] got %0d want %0d",
                         k, cyc, ecyc[k]);
            else passed++;
            checks++;
            if (pc_o !== 32'(epc[k]))
                $display("FAIL dir_pc[%0d] got %0d want %0d",
                         k, pc_o, epc[k]);
            else passed++;
            checks++;
            if (nwe != est[k])
                $display("FAIL dir_we_count[%0d] got %0d want %0d",
                         k, nwe, est[k]);
            else passed++;
            if (est[k] == 1) begin
                checks++;
                if (wa !== 6'(esa[k]) || wd !== esd[k])
                    $display("FAIL dir_store[%0d] got %0d/%h want %0d/%h",
                             k, wa, wd, esa[k], esd[k]);
                else passed++;
            end
        end
        checks++;
        if (state_o !== 3'd5 || halted !== 1'b1)
            $display("FAIL dir_halt got %0d/%b want 5/1", state_o, halted);
        else passed++;
    endtask

    task automatic test_halt();
        int cyc, nwe, bad;
        logic [5:0] wa;
        logic [31:0] wd;
        for (int v = 0; v < 2; v++) begin
            fill_mem();
            for (int i = 0; i < 5; i++) imem[i] = enc_i(19, 0, 0, 0, 0);
            imem[5] = (v == 0) ? 32'h00000073 : 32'h0000007F;
            do_reset();
            for (int i = 0; i < 6; i++) dut_step(cyc, nwe, wa, wd);
            checks++;
            if (cyc != 2 || state_o !== 3'd5 || halted !== 1'b1)
                $display("FAIL halt_entry[%0d] got %0d/%0d/%b want 2/5/1",
                         v, cyc, state_o, halted);
            else passed++;
            bad = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (pc_o !== 32'd20 || halted !== 1'b1 ||
                    state_o !== 3'd5 || dmem_we !== 1'b0) bad++;
            end
            checks++;
            if (bad != 0)
                $display("FAIL halt_frozen[%0d] got %0d bad cycles want 0",
                         v, bad);
            else passed++;
        end
    endtask

    task automatic test_branch();
        int cyc, nwe;
        logic [5:0] wa;
        logic [31:0] wd;
        for (int v = 0; v < 2; v++) begin
            fill_mem();
            for (int i = 0; i < 4; i++) imem[i] = enc_i(19, 0, 1, 1, 3);
            imem[4] = enc_b(v, 1, 1, -8);
            do_reset();
            for (int i = 0; i < 5; i++) dut_step(cyc, nwe, wa, wd);
            checks++;
            if (cyc != 3)
                $display("FAIL br_cycles[%0d] got %0d want 3", v, cyc);
            else passed++;
            checks++;
            if (pc_o !== ((v == 0) ? 32'd8 : 32'd20))
                $display("FAIL br_pc[%0d] got %0d want %0d",
                         v, pc_o, (v == 0) ? 8 : 20);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_store();
        int cyc, nwe, n;
        logic [5:0] wa;
        logic [31:0] wd, old;
        fill_mem();
        imem[0] = enc_i(19, 0, 3, 0, 'h55);
        imem[1] = enc_s(0, 3, 8);
        old = dmem[2];
        do_reset();
        dut_step(cyc, nwe, wa, wd);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (state_o != 3'd3 && n < 10);
        checks++;
        if (state_o !== 3'd3 || dmem_we !== 1'b1)
            $display("FAIL mid_reach_mem got %0d/%b want 3/1",
                     state_o, dmem_we);
        else passed++;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (dmem_we !== 1'b0 || state_o !== 3'd0 || pc_o !== 32'd0)
            $display("FAIL mid_abort got %b/%0d/%0d want 0/0/0",
                     dmem_we, state_o, pc_o);
        else passed++;
        @(negedge clk);
        reset = 1'b1;
        checks++;
        if (dmem[2] !== old)
            $display("FAIL mid_mem_kept got %h want %h", dmem[2], old);
        else passed++;
        dut_step(cyc, nwe, wa, wd);
        dut_step(cyc, nwe, wa, wd);
        checks++;
        if (nwe != 1 || wa !== 6'd2 || wd !== 32'h55 || pc_o !== 32'd8)
            $display("FAIL mid_restart got %0d/%0d/%h/%0d want 1/2/55/8",
                     nwe, wa, wd, pc_o);
        else passed++;
    endtask

    function automatic logic [31:0] gen_instr();
        int k, rd, rs1, rs2, imm, off;
        k   = $urandom_range(0, 13);
        rd  = $urandom_range(0, 7);
        rs1 = $urandom_range(0, 7);
        rs2 = $urandom_range(0, 7);
        imm = $urandom_range(0, 4095);
        off = (int'($urandom_range(0, 16)) - 8) * 4;
        if (off == 0) off = 8;
        case (k)
            0:  return enc_r(0, 0, rd, rs1, rs2);
            1:  return enc_r(32, 0, rd, rs1, rs2);
            2:  return enc_r(0, 2, rd, rs1, rs2);
            3:  return enc_r(0, 4, rd, rs1, rs2);
            4:  return enc_r(0, 6, rd, rs1, rs2);
            5:  return enc_r(0, 7, rd, rs1, rs2);
            6:  return enc_i(19, 0, rd, rs1, imm);
            7:  return enc_i(19, 6, rd, rs1, imm);
            8:  return enc_i(19, 7, rd, rs1, imm);
            9:  return enc_i(3, 2, rd, rs1, imm);
            10: return enc_s(rs1, rs2, imm);
            11: return enc_b(0, rs1, rs2, off);
            12: return enc_b(1, rs1, rs2, off);
            default: return enc_i(19, 0, rd, 0, imm);
        endcase
    endfunction

    task automatic test_random();
        int cyc, nwe, ecyc, bad;
        bit est, ehlt;
        logic [5:0] wa, esa;
        logic [31:0] wd, esd;
        for (int r = 0; r < 3; r++) begin
            fill_mem();
            for (int i = 0; i < 63; i++) imem[i] = gen_instr();
            do_reset();
            ehlt = 0;
            for (int s = 0; s < 300 && !ehlt; s++) begin
                model_step(ecyc, est, esa, esd, ehlt);
                dut_step(cyc, nwe, wa, wd);
                checks++;
                if (cyc != ecyc || pc_o !== mpc)
                    $display("FAIL rnd_step[%0d.%0d] got %0d/%h want %0d/%h",
                             r, s, cyc, pc_o, ecyc, mpc);
                else passed++;
                checks++;
                if (nwe != int'(est) ||
                    (est && (wa !== esa || wd !== esd)))
                    $display("FAIL rnd_store[%0d.%0d] got %0d/%0d/%h want %0d/%0d/%h",
                             r, s, nwe, wa, wd, est, esa, esd);
                else passed++;
            end
            @(negedge clk);
            bad = 0;
            for (int i = 0; i < 64; i++) if (dmem[i] !== mmem[i]) bad++;
            checks++;
            if (bad != 0)
                $display("FAIL rnd_mem[%0d] got %0d differing words want 0",
                         r, bad);
            else passed++;
        end
    endtask

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 64; i++) imem[i] = 32'h00000073;
        test_reset();
        test_directed();
        test_halt();
        test_branch();
        test_reset_mid_store();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fase2_multiciclo.md
FASE2_MULTICICLO -- requirements
Module: fase2_multiciclo

Interface
REQ-001 SHALL provide parameter XLEN, default 32, datapath and register width.
REQ-002 SHALL provide parameter IMEM_AW, default 6, instruction word-address width (64 words).
REQ-003 SHALL provide parameter DMEM_AW, default 6, data word-address width (64 words).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 imem_addr  output  IMEM_AW  word address of instruction to fetch (PC[IMEM_AW+1:2]).
REQ-007 imem_data  input  32  instruction word; combinational read, valid same cycle.
REQ-008 dmem_addr  output  DMEM_AW  data word address (ALU result bits [DMEM_AW+1:2]).
REQ-009 dmem_wdata  output  XLEN  store data (rs2 value).
REQ-010 dmem_we  output  1  store strobe; external memory writes on rising edge when high.
REQ-011 dmem_rdata  input  XLEN  load data; combinational read.
REQ-012 pc_o  output  XLEN  current PC.
REQ-013 state_o  output  3  current FSM state encoding.
REQ-014 halted  output  1  high while in HALT.

Function
REQ-015 SHALL implement a multicycle RV32I subset: R-type ADD/SUB/AND/OR/XOR/SLT, I-type ADDI/ANDI/ORI, LW, SW, BEQ, BNE, ECALL.
REQ-016 FSM states: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=5.
REQ-017 FETCH: latch imem_data into IR; next DECODE.
REQ-018 DECODE: latch rs1/rs2 register values into A/B and sign-extended immediate; unknown opcode or ECALL -> HALT; otherwise EXECUTE.
REQ-019 EXECUTE: latch ALU result into ALUOut; branches resolve here (PC <= PC+imm if taken, else PC+4) -> FETCH; LW/SW -> MEM; R/I -> WB.
REQ-020 MEM: SW asserts dmem_we for exactly this one cycle, PC <= PC+4, -> FETCH; LW latches dmem_rdata into MDR -> WB.
REQ-021 WB: write ALUOut (R/I) or MDR (LW) to rd; PC <= PC+4; -> FETCH.
REQ-022 Latency per instruction, FETCH to next FETCH: branch 3, R/I 4, SW 4, LW 5 cycles.
REQ-023 Register file: 32 x XLEN, internal, two combinational reads, one synchronous write; x0 reads 0, writes to x0 discarded.
REQ-024 Arithmetic: XLEN-bit, wrap-around on overflow, no flags; SLT signed; immediates sign-extended to XLEN.
REQ-025 PC wraps modulo 2^XLEN; imem_addr/dmem_addr truncate upper bits (memory aliasing, no fault).
REQ-026 Misaligned address bits [1:0] SHALL be ignored.
REQ-027 HALT is absorbing: no PC change, no register write, dmem_we low, until reset.
REQ-028 dmem_we SHALL be low in every state other than MEM of a SW.

Reset
REQ-029 On reset low, immediately: state FETCH, PC 0, IR/A/B/ALUOut/MDR 0, all registers 0, dmem_we 0, halted 0.
REQ-030 Reset asserted mid-instruction SHALL abort it with no register or memory write; execution restarts at PC 0 on the first edge after release.

Structure
REQ-031 Shared package fase2_pkg SHALL hold opcode/funct3/funct7 constants, the state enum, and the ALU-operation enum.
REQ-032 One sub-module, control_unit, SHALL contain the FSM and decode, outputting datapath enables and ALU op; datapath stays in fase2_multiciclo.

Verification
REQ-033 ADDI x1,x0,5; ADDI x2,x0,7; ADD x3,x1,x2 -> x3=12, ADD takes 4 cycles, PC=12 after.
REQ-034 SW x3,8(x0) then LW x4,8(x0) -> dmem_we high one cycle with addr 2, data 12; x4=12; LW takes 5 cycles.
REQ-035 BEQ x1,x1,-8 at PC=16 -> PC=8 after 3 cycles; BNE x1,x1,-8 -> PC=20.
REQ-036 ADDI x0,x0,9 then ADD x5,x0,x0 -> x5=0.
REQ-037 ECALL or opcode 0x7F -> halted=1, state_o=5, PC frozen for 20 cycles.
REQ-038 Reset pulse during MEM of a SW -> dmem_we drops immediately, memory unchanged, PC=0 after release.
